// File: rtl/swipt_pwm_gen_if.sv
// Frequency request in, complementary half-bridge drive and status out.
// The master modport belongs to the requester; the slave modport belongs to the drive stage.
interface swipt_pwm_gen_if;
  logic        enable;
  logic [19:0] freq;
  logic        gate_hi;
  logic        gate_lo;
  logic        period_tick;
  logic [19:0] freq_applied;
  logic        busy;

  modport master (
    output enable,
    output freq,
    input  gate_hi,
    input  gate_lo,
    input  period_tick,
    input  freq_applied,
    input  busy
  );

  modport slave (
    input  enable,
    input  freq,
    output gate_hi,
    output gate_lo,
    output period_tick,
    output freq_applied,
    output busy
  );
endinterface

// File: rtl/swipt_pwm_gen.sv
// Frequency word -> complementary half-bridge gates with fixed dead time; 33-cycle restoring divider
// computes the half period, and new results are applied only at a period boundary. All outputs registered.
module swipt_pwm_gen #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned DEAD_CYCLES = 20,
  parameter logic [19:0] FMIN        = 20'd30000,
  parameter logic [19:0] FMAX        = 20'd50000
) (
  input  logic             clk,
  input  logic             nrst,
  swipt_pwm_gen_if.slave   bus
);

  localparam logic [31:0] DIVIDEND = 32'(CLK_HZ);
  localparam logic [23:0] DEAD     = 24'(DEAD_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HI_DEAD = 3'd1,
    S_HI_ON   = 3'd2,
    S_LO_DEAD = 3'd3,
    S_LO_ON   = 3'd4
  } state_t;

  logic [19:0] f_c;

  logic        tgt_vld_q, tgt_vld_d;
  logic [19:0] div_target_q, div_target_d;
  logic        div_run_q, div_run_d;
  logic [5:0]  div_cnt_q, div_cnt_d;
  logic [31:0] div_dvd_q, div_dvd_d;
  logic [31:0] div_quo_q, div_quo_d;
  logic [20:0] div_rem_q, div_rem_d;
  logic [20:0] div_dsr_q, div_dsr_d;
  logic [21:0] rem_sh;
  logic        rem_ge;
  logic        div_store;
  logic [23:0] quo_sat;

  logic        pend_vld_q, pend_vld_d;
  logic [23:0] pend_half_q, pend_half_d;
  logic [19:0] pend_freq_q, pend_freq_d;

  state_t      state_q, state_d;
  logic [23:0] hcnt_q, hcnt_d;
  logic [23:0] active_half_q, active_half_d;
  logic        applied_q, applied_d;
  logic [19:0] freq_app_q, freq_app_d;
  logic        tick_q, tick_d;
  logic        hi_q, hi_d;
  logic        lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        boundary;

  always_comb begin
    f_c = bus.freq;
    if (f_c < FMIN) f_c = FMIN;
    if (f_c > FMAX) f_c = FMAX;
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh  = {div_rem_q, div_dvd_q[31]};
    rem_ge  = (rem_sh >= {1'b0, div_dsr_q});
    quo_sat = (|div_quo_q[31:24]) ? 24'hFF_FFFF : div_quo_q[23:0];
  end

  // A changed target always restarts, even on the cycle that would have stored the stale quotient.
  always_comb begin
    tgt_vld_d    = tgt_vld_q;
    div_target_d = div_target_q;
    div_run_d    = div_run_q;
    div_cnt_d    = div_cnt_q;
    div_dvd_d    = div_dvd_q;
    div_quo_d    = div_quo_q;
    div_rem_d    = div_rem_q;
    div_dsr_d    = div_dsr_q;
    div_store    = 1'b0;
    if (!tgt_vld_q || (f_c != div_target_q)) begin
      tgt_vld_d    = 1'b1;
      div_target_d = f_c;
      div_run_d    = 1'b1;
      div_cnt_d    = 6'd0;
      div_dvd_d    = DIVIDEND;
      div_quo_d    = 32'd0;
      div_rem_d    = 21'd0;
      div_dsr_d    = {f_c, 1'b0};
    end else if (div_run_q) begin
      if (div_cnt_q == 6'd32) begin
        div_run_d = 1'b0;
        div_store = 1'b1;
      end else begin
        div_rem_d = rem_ge ? 21'(rem_sh - {1'b0, div_dsr_q}) : rem_sh[20:0];
        div_quo_d = {div_quo_q[30:0], rem_ge};
        div_dvd_d = {div_dvd_q[30:0], 1'b0};
        div_cnt_d = div_cnt_q + 6'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q + 24'd1;
    case (state_q)
      S_IDLE: begin
        hcnt_d = 24'd0;
        if (bus.enable && (pend_vld_q || applied_q)) state_d = S_HI_DEAD;
      end
      S_HI_DEAD: if (hcnt_q == DEAD - 24'd1) state_d = S_HI_ON;
      S_HI_ON: begin
        if (hcnt_q == active_half_q - 24'd1) begin
          state_d = S_LO_DEAD;
          hcnt_d  = 24'd0;
        end
      end
      S_LO_DEAD: if (hcnt_q == DEAD - 24'd1) state_d = S_LO_ON;
      S_LO_ON: begin
        if (hcnt_q == active_half_q - 24'd1) begin
          state_d = S_HI_DEAD;
          hcnt_d  = 24'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        hcnt_d  = 24'd0;
      end
    endcase
    if (!bus.enable) begin
      state_d = S_IDLE;
      hcnt_d  = 24'd0;
    end

    boundary      = (state_d == S_HI_DEAD) && (state_q != S_HI_DEAD);
    active_half_d = active_half_q;
    freq_app_d    = freq_app_q;
    applied_d     = applied_q;
    pend_vld_d    = pend_vld_q;
    pend_half_d   = pend_half_q;
    pend_freq_d   = pend_freq_q;
    if (boundary && pend_vld_q) begin
      active_half_d = pend_half_q;
      freq_app_d    = pend_freq_q;
      applied_d     = 1'b1;
      pend_vld_d    = 1'b0;
    end
    // A result landing on a boundary stays pending for the next period.
    if (div_store) begin
      pend_vld_d  = 1'b1;
      pend_half_d = quo_sat;
      pend_freq_d = div_target_q;
    end

    tick_d = boundary;
    hi_d   = (state_d == S_HI_ON);
    lo_d   = (state_d == S_LO_ON);
    busy_d = div_run_d | pend_vld_d;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tgt_vld_q     <= 1'b0;
      div_target_q  <= 20'd0;
      div_run_q     <= 1'b0;
      div_cnt_q     <= 6'd0;
      div_dvd_q     <= 32'd0;
      div_quo_q     <= 32'd0;
      div_rem_q     <= 21'd0;
      div_dsr_q     <= 21'd0;
      pend_vld_q    <= 1'b0;
      pend_half_q   <= 24'd0;
      pend_freq_q   <= FMIN;
      state_q       <= S_IDLE;
      hcnt_q        <= 24'd0;
      active_half_q <= 24'd0;
      applied_q     <= 1'b0;
      freq_app_q    <= FMIN;
      tick_q        <= 1'b0;
      hi_q          <= 1'b0;
      lo_q          <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      tgt_vld_q     <= tgt_vld_d;
      div_target_q  <= div_target_d;
      div_run_q     <= div_run_d;
      div_cnt_q     <= div_cnt_d;
      div_dvd_q     <= div_dvd_d;
      div_quo_q     <= div_quo_d;
      div_rem_q     <= div_rem_d;
      div_dsr_q     <= div_dsr_d;
      pend_vld_q    <= pend_vld_d;
      pend_half_q   <= pend_half_d;
      pend_freq_q   <= pend_freq_d;
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      active_half_q <= active_half_d;
      applied_q     <= applied_d;
      freq_app_q    <= freq_app_d;
      tick_q        <= tick_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.gate_hi      = hi_q;
  assign bus.gate_lo      = lo_q;
  assign bus.period_tick  = tick_q;
  assign bus.freq_applied = freq_app_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_swipt_pwm_gen.sv
// Bench for swipt_pwm_gen: cycle model of period position and divider countdown, compared every cycle,
// plus directed scenarios pinned by hand-computed period lengths and latencies.
module tb_swipt_pwm_gen;

  localparam int CLK_HZ = 100_000_000;
  localparam int DEAD   = 20;
  localparam int FMIN   = 30000;
  localparam int FMAX   = 50000;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   cyc  = 0;
  int   checks = 0;
  int   errors = 0;

  swipt_pwm_gen_if bus ();

  swipt_pwm_gen #(
    .CLK_HZ      (CLK_HZ),
    .DEAD_CYCLES (DEAD),
    .FMIN        (20'd30000),
    .FMAX        (20'd50000)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state: divider as a countdown to the store edge, drive as a position within the period.
  int m_tgt = 0, m_left = 0, m_pend_half = 0, m_pend_freq = FMIN;
  int m_pos = 0, m_h = 0, m_fapp = FMIN, m_fc = 0;
  bit m_tgt_vld = 0, m_pend = 0, m_run = 0, m_applied = 0;
  bit m_store = 0, m_bnd = 0, m_pend_old = 0;
  bit e_hi = 0, e_lo = 0, e_tick = 0, e_busy = 0;
  int e_fapp = FMIN;

  function automatic int clampf(input int f);
    if (f < FMIN) return FMIN;
    if (f > FMAX) return FMAX;
    return f;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_tgt_vld = 0; m_left = 0; m_pend = 0; m_run = 0; m_applied = 0;
      m_pos = 0; m_fapp = FMIN;
      e_hi = 0; e_lo = 0; e_tick = 0; e_busy = 0; e_fapp = FMIN;
    end else begin
      m_fc = clampf(int'(bus.freq));
      m_store = 0;
      if (!m_tgt_vld || m_fc != m_tgt) begin
        m_tgt = m_fc; m_tgt_vld = 1; m_left = 33;
      end else if (m_left == 1) begin
        m_store = 1; m_left = 0;
      end else if (m_left > 0) begin
        m_left = m_left - 1;
      end
      m_pend_old = m_pend;
      m_bnd = 0;
      if (!bus.enable) begin
        m_run = 0;
      end else if (!m_run) begin
        if (m_pend || m_applied) begin m_run = 1; m_pos = 0; m_bnd = 1; end
      end else begin
        m_pos = m_pos + 1;
        if (m_pos == 2 * m_h) begin m_pos = 0; m_bnd = 1; end
      end
      if (m_bnd && m_pend_old) begin
        m_h = m_pend_half; m_fapp = m_pend_freq; m_applied = 1; m_pend = 0;
      end
      if (m_store) begin
        m_pend = 1; m_pend_half = CLK_HZ / (2 * m_tgt); m_pend_freq = m_tgt;
        if (m_pend_half > 24'hFFFFFF) m_pend_half = 24'hFFFFFF;
      end
      e_tick = m_bnd;
      e_hi   = m_run && m_pos >= DEAD && m_pos < m_h;
      e_lo   = m_run && m_pos >= m_h + DEAD;
      e_busy = (m_left > 0) || m_pend;
      e_fapp = m_fapp;
    end
  end

  always @(negedge clk) begin
    checks++;
    if (bus.gate_hi !== e_hi || bus.gate_lo !== e_lo || bus.period_tick !== e_tick ||
        int'(bus.freq_applied) != e_fapp || bus.busy !== e_busy) begin
      errors++;
      $display("FAIL model cycle %0d: got hi=%b lo=%b tick=%b fapp=%0d busy=%b, want hi=%b lo=%b tick=%b fapp=%0d busy=%b",
               cyc, bus.gate_hi, bus.gate_lo, bus.period_tick, bus.freq_applied, bus.busy,
               e_hi, e_lo, e_tick, e_fapp, e_busy);
    end
    checks++;
    if (bus.gate_hi && bus.gate_lo) begin
      errors++;
      $display("FAIL overlap cycle %0d: both gates high", cyc);
    end
    if (errors > 50) begin
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  int hi_run = 0, lo_run = 0, last_hi_len = 0, last_lo_len = 0;
  always @(negedge clk) begin
    if (bus.gate_hi) hi_run++;
    else if (hi_run > 0) begin last_hi_len = hi_run; hi_run = 0; end
    if (bus.gate_lo) lo_run++;
    else if (lo_run > 0) begin last_lo_len = lo_run; lo_run = 0; end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic wait_tick(output int t);
    t = -1;
    for (int k = 0; k < 8000; k++) begin
      @(negedge clk); #1;
      if (bus.period_tick) begin t = cyc; break; end
    end
    if (t < 0) begin
      checks++; errors++;
      $display("FAIL tick_timeout: no period_tick within 8000 cycles");
    end
  endtask

  task automatic wait_applied(input int f, output int t);
    int tt;
    t = -1;
    for (int k = 0; k < 4; k++) begin
      wait_tick(tt);
      if (tt < 0) break;
      if (int'(bus.freq_applied) == f) begin t = tt; break; end
    end
    chk("applied_freq", int'(bus.freq_applied), f);
  endtask

  task automatic wait_gate(input bit lo);
    bit ok;
    ok = 0;
    for (int k = 0; k < 8000; k++) begin
      @(negedge clk); #1;
      if ((lo ? bus.gate_lo : bus.gate_hi) == 1'b1) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL gate_timeout: gate %0d never rose", lo);
    end
  endtask

  task automatic drive_freq(input int f);
    @(posedge clk); #2;
    bus.freq = 20'(f);
  endtask

  // Reset release, first division, first two periods at 35 kHz.
  task automatic reset_scenario();
    int e, t1, t2;
    @(posedge clk); #2;
    nrst = 1'b1;
    @(posedge clk); #1;
    e = cyc;
    chk("busy_after_first_edge", int'(bus.busy), 1);
    wait_tick(t1);
    chk("first_tick_latency", t1 - e, 34);
    chk("first_fapp", int'(bus.freq_applied), 35000);
    wait_tick(t2);
    chk("period_35k", t2 - t1, 2856);
    chk("hi_len_35k", last_hi_len, 1408);
    chk("lo_len_35k", last_lo_len, 1408);
  endtask

  int t_a, t_b, t_c, tk, rise;
  bit seen_40k;

  initial begin
    bus.enable = 1'b1;
    bus.freq   = 20'h88B8;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_gate_hi", int'(bus.gate_hi), 0);
    chk("rst_gate_lo", int'(bus.gate_lo), 0);
    chk("rst_tick", int'(bus.period_tick), 0);
    chk("rst_fapp", int'(bus.freq_applied), FMIN);
    chk("rst_busy", int'(bus.busy), 0);

    reset_scenario();

    // Step 35k -> 45k while the high side is conducting.
    wait_gate(1'b0);
    wait_tick(t_a);
    wait_gate(1'b0);
    drive_freq(45000);
    wait_tick(t_b);
    chk("period_before_step", t_b - t_a, 2856);
    chk("fapp_on_step_tick", int'(bus.freq_applied), 45000);
    wait_tick(t_c);
    chk("period_45k", t_c - t_b, 2222);

    // Abort a 40k division mid-flight with 42k.
    drive_freq(40000);
    repeat (20) @(posedge clk);
    #2 bus.freq = 20'd42000;
    seen_40k = 0;
    t_a = -1;
    for (int k = 0; k < 16000; k++) begin
      @(negedge clk); #1;
      if (int'(bus.freq_applied) == 40000) seen_40k = 1;
      if (bus.period_tick && int'(bus.freq_applied) == 42000) begin t_a = cyc; break; end
    end
    chk("abort_applied_42k", int'(bus.freq_applied), 42000);
    chk("abort_never_40k", int'(seen_40k), 0);
    wait_tick(t_b);
    chk("period_42k", t_b - t_a, 2380);

    // Clamping at both ends.
    drive_freq(0);
    wait_applied(30000, t_a);
    wait_tick(t_b);
    chk("period_clamp_lo", t_b - t_a, 3332);
    drive_freq(20'hFFFFF);
    wait_applied(50000, t_a);
    wait_tick(t_b);
    chk("period_clamp_hi", t_b - t_a, 2000);

    // Drop enable during the low-side on-time, then re-enable.
    wait_gate(1'b1);
    @(posedge clk); #2 bus.enable = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    chk("dis_gate_lo", int'(bus.gate_lo), 0);
    chk("dis_gate_hi", int'(bus.gate_hi), 0);
    repeat (10) @(posedge clk);
    #2 bus.enable = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    chk("reenable_tick", int'(bus.period_tick), 1);
    tk = cyc;
    wait_gate(1'b0);
    rise = cyc;
    chk("reenable_dead", rise - tk, 20);

    // Asynchronous reset while the high side conducts.
    wait_gate(1'b0);
    @(posedge clk); #2;
    nrst = 1'b0;
    bus.freq = 20'd35000;
    #1;
    chk("async_rst_gate_hi", int'(bus.gate_hi), 0);
    chk("async_rst_busy", int'(bus.busy), 0);
    repeat (3) @(posedge clk);
    reset_scenario();

    // Randomised requests and enable toggling.
    for (int i = 0; i < 25; i++) begin
      int r;
      r = $urandom_range(0, 9);
      @(posedge clk); #2;
      if (r <= 5) begin
        if ($urandom_range(0, 2) == 0) bus.freq = 20'($urandom);
        else bus.freq = 20'($urandom_range(FMIN, FMAX));
        repeat ($urandom_range(1, 1200)) @(posedge clk);
      end else if (r <= 7) begin
        bus.enable = ~bus.enable;
        repeat ($urandom_range(1, 800)) @(posedge clk);
      end else begin
        bus.freq = 20'($urandom_range(FMIN - 2000, FMAX + 2000));
        repeat ($urandom_range(1, 40)) @(posedge clk);
      end
    end
    @(posedge clk); #2 bus.enable = 1'b1;
    repeat (3500) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
